// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with frame detect, show-ahead output and optional idle timeout (UART_RX_FIFO_TIMEOUT_EN)
module uart_rx_fifo #(
  parameter int DEPTH          = 16,
  parameter int AF_LEVEL       = 12,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_ready,
  input  logic [7:0]               rx_data,
  input  logic                     rx_parity_valid,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [7:0]               m_data,
  output logic                     m_perr,
  input  logic                     flush,
  input  logic                     clr_ovf,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overflow,
  output logic                     timeout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

  // Entry layout: bit 8 = parity error tag, bits 7:0 = received byte.
  logic [8:0]    mem_q [DEPTH];

  logic          rdy_prev_q;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          push_req;
  logic          pop;
  logic          room;
  logic          accept;
  logic          drop;
  logic [8:0]    head;

  assign push_req = rx_ready & ~rdy_prev_q;
  assign m_valid  = (count_q != '0);
  assign pop      = m_valid & m_ready & ~flush;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign room     = (count_q < DEPTH_C) | (m_valid & m_ready);
  assign accept   = push_req & room & ~flush;
  assign drop     = push_req & ~room & ~flush;

  assign head        = mem_q[rd_ptr_q];
  assign m_data      = m_valid ? head[7:0] : 8'h00;
  assign m_perr      = m_valid ? head[8] : 1'b0;
  assign count       = count_q;
  assign almost_full = (count_q >= AF_C);
  assign overflow    = overflow_q;

  // Next-state for pointers, fill count and the sticky overflow flag; flush overrides everything.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (accept) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      case ({accept, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (clr_ovf) begin
        overflow_d = 1'b0;
      end
      if (drop) begin
        overflow_d = 1'b1;
      end
    end
  end

  // Control state registers; rdy_prev resets high so an idle-high receiver is not seen as a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_prev_q <= 1'b1;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rdy_prev_q <= rx_ready;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array is not reset; the head output is gated while empty instead.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= {~rx_parity_valid, rx_data};
    end
  end

`ifdef UART_RX_FIFO_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic        timeout_q, timeout_d;
  logic        idle_clr;

  assign idle_clr = accept | flush | (count_q == '0);
  assign timeout  = timeout_q;

  // Saturating idle counter; timeout latches when the counter reaches the limit.
  always_comb begin
    idle_d    = idle_q;
    timeout_d = timeout_q;
    if (idle_clr) begin
      idle_d    = '0;
      timeout_d = 1'b0;
    end else begin
      if (idle_q != '1) begin
        idle_d = idle_q + 32'd1;
      end
      if (idle_d == 32'(TIMEOUT_CYCLES)) begin
        timeout_d = 1'b1;
      end
    end
  end

  // Idle counter and timeout flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue-based reference model
module tb_uart_rx_fifo;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int TO    = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_parity_valid;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_perr;
  logic       flush;
  logic       clr_ovf;
  logic [2:0] count;
  logic       almost_full;
  logic       overflow;
  logic       timeout;

  int tests = 0;
  int fails = 0;

  logic [8:0] mq[$];
  bit         m_ovf;
  bit         m_prev;
  int         m_idle;

  always #20 clk = ~clk;

  uart_rx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AF), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_parity_valid(rx_parity_valid), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_perr(m_perr), .flush(flush), .clr_ovf(clr_ovf),
    .count(count), .almost_full(almost_full), .overflow(overflow), .timeout(timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [8:0] h;
    bit         exp_to;
    h = (mq.size() != 0) ? mq[0] : 9'h000;
`ifdef UART_RX_FIFO_TIMEOUT_EN
    exp_to = (m_idle >= TO);
`else
    exp_to = 1'b0;
`endif
    check({tag, ".count"},   32'(count),       32'(mq.size()));
    check({tag, ".m_valid"}, 32'(m_valid),     32'(mq.size() != 0));
    check({tag, ".m_data"},  32'(m_data),      32'(h[7:0]));
    check({tag, ".m_perr"},  32'(m_perr),      32'(h[8]));
    check({tag, ".ovf"},     32'(overflow),    32'(m_ovf));
    check({tag, ".af"},      32'(almost_full), 32'(mq.size() >= AF));
    check({tag, ".timeout"}, 32'(timeout),     32'(exp_to));
  endtask

  // One clock: update the model from the inputs presented this cycle, then compare after the edge.
  task automatic cycle(input string tag);
    bit push, pop, acc;
    int s0;
    s0   = mq.size();
    push = rx_ready && !m_prev;
    pop  = (s0 > 0) && m_ready;
    acc  = 1'b0;
    if (flush) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_idle = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (clr_ovf) m_ovf = 1'b0;
      if (push) begin
        if (mq.size() < DEPTH) begin
          mq.push_back({~rx_parity_valid, rx_data});
          acc = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (acc || s0 == 0) m_idle = 0;
      else m_idle++;
    end
    m_prev = rx_ready;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic send(input logic [7:0] d, input bit pv, input bit pop_too, input bit fl);
    rx_ready = 1'b0;
    cycle("frame_low");
    rx_ready        = 1'b1;
    rx_data         = d;
    rx_parity_valid = pv;
    m_ready         = pop_too;
    flush           = fl;
    cycle("frame_push");
    m_ready = 1'b0;
    flush   = 1'b0;
  endtask

  task automatic wait_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    rst_n = 1'b0; rx_ready = 1'b1; rx_data = 8'h00; rx_parity_valid = 1'b1;
    m_ready = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_prev = 1'b1; m_idle = 0;

    // Reset with receiver idle-high, then release: no spurious entry.
    repeat (3) @(posedge clk);
    #1;
    check_all("in_reset");
    rst_n = 1'b1;
    wait_cycles(3, "post_reset");

    // Three good frames, then drain in order.
    send(8'h55, 1'b1, 1'b0, 1'b0);
    send(8'hA3, 1'b1, 1'b0, 1'b0);
    send(8'h0F, 1'b1, 1'b0, 1'b0);
    m_ready = 1'b1;
    wait_cycles(4, "drain3");
    m_ready = 1'b0;

    // Overfill: 0x05 dropped, almost_full from the third entry.
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0, 1'b0);
    clr_ovf = 1'b1;
    cycle("clr_ovf");
    clr_ovf = 1'b0;
    m_ready = 1'b1;
    wait_cycles(5, "drain4");
    m_ready = 1'b0;

    // Full FIFO with push and pop together, plus pointer wrap.
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
    send(8'hC4, 1'b1, 1'b1, 1'b0);
    send(8'hC5, 1'b1, 1'b1, 1'b0);
    m_ready = 1'b1;
    wait_cycles(5, "drain_wrap");
    m_ready = 1'b0;

    // Parity error tag, then flush colliding with a push.
    send(8'h7E, 1'b0, 1'b0, 1'b0);
    send(8'h99, 1'b1, 1'b0, 1'b1);
    wait_cycles(2, "after_flush");

    // Drop and clr_ovf in the same cycle: the drop wins.
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 1'b1, 1'b0, 1'b0);
    rx_ready = 1'b0;
    cycle("drop_low");
    rx_ready = 1'b1; rx_data = 8'h2F; clr_ovf = 1'b1;
    cycle("drop_vs_clr");
    clr_ovf = 1'b0;
    flush = 1'b1;
    cycle("flush_full");
    flush = 1'b0;

    // Idle timeout: one byte held, then a new push clears it.
    send(8'h11, 1'b1, 1'b0, 1'b0);
    wait_cycles(13, "idle_hold");
    send(8'h22, 1'b1, 1'b0, 1'b0);
    wait_cycles(2, "idle_cleared");
    m_ready = 1'b1;
    wait_cycles(3, "idle_drain");
    m_ready = 1'b0;

    // Asynchronous reset in the middle of operation empties the FIFO at once.
    send(8'h33, 1'b1, 1'b0, 1'b0);
    send(8'h44, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    mq.delete(); m_ovf = 1'b0; m_idle = 0; m_prev = 1'b1;
    check_all("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cycles(2, "after_async_reset");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rx_ready        = ($urandom_range(0, 2) != 0);
      rx_data         = 8'($urandom);
      rx_parity_valid = ($urandom_range(0, 3) != 0);
      m_ready         = ($urandom_range(0, 2) == 0);
      clr_ovf         = ($urandom_range(0, 15) == 0);
      flush           = ($urandom_range(0, 63) == 0);
      cycle("random");
    end
    flush = 1'b0; clr_ovf = 1'b0; m_ready = 1'b0; rx_ready = 1'b1;
    wait_cycles(2, "final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
